// File: rtl/adel_imem_ctrl.sv
// adel_imem_ctrl: run controller and instruction-memory arbiter for the adel
// 16-bit core. One single-port sync-read SRAM is shared between the host
// loader (IDLE/HALT only) and core fetch (RUN_F). The core is driven through a
// registered active-low reset and a clock enable. Each instruction takes two
// cycles: RUN_F issues the read and RUN_E presents the word and retires it.
// Optional feature macro: RETIRE_CNT_EN adds a 32-bit retired-instruction
// counter on port retire_cnt.
module adel_imem_ctrl #(
    parameter int          DEPTH     = 256,
    parameter int          AW        = $clog2(DEPTH),
    parameter logic [15:0] HALT_WORD = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [15:0]   ld_addr,
    input  logic [15:0]   ld_data,
    input  logic          start,
    input  logic          stop,
    input  logic          step,
    input  logic          clr,
    input  logic [15:0]   core_pc,
    output logic [15:0]   core_inst,
    output logic          core_ce,
    output logic          core_rst_n,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    output logic          running,
    output logic          halted,
`ifdef RETIRE_CNT_EN
    output logic [31:0]   retire_cnt,
`endif
    output logic          pc_fault
);

    typedef enum logic [1:0] {S_IDLE, S_RUN_F, S_RUN_E, S_HALT} state_t;

    // 17-bit compare so that a full 16-bit address can be tested against DEPTH
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      r_state;
    logic        r_core_rst_n;
    logic        r_pc_fault;
    logic [15:0] r_inst;
    logic        r_stop_seen;   // stop arrived during the current RUN_F/RUN_E pair
    logic        r_one_shot;    // current pair was entered by step

    logic w_beat;
    logic w_wr;
    logic w_pc_ok;
    logic w_fetch;
    logic w_is_halt;
    logic w_retire;
    logic w_in_run_e;

    assign w_in_run_e = (r_state == S_RUN_E);
    assign ld_ready   = !rst && (r_state == S_IDLE || r_state == S_HALT);
    assign w_beat     = ld_valid && ld_ready;
    // out-of-range beats are still accepted, the write is just dropped
    assign w_wr       = w_beat && ({1'b0, ld_addr} < DEPTH_W);
    assign w_pc_ok    = ({1'b0, core_pc} < DEPTH_W);
    assign w_fetch    = (r_state == S_RUN_F) && w_pc_ok;
    assign w_is_halt  = (mem_rdata == HALT_WORD);
    // the halt word is never executed, so it produces no core edge
    assign w_retire   = w_in_run_e && !w_is_halt;

    // loader and fetch never overlap: ld_ready is low in both RUN states
    assign mem_en     = w_wr || w_fetch;
    assign mem_we     = w_wr;
    assign mem_addr   = w_wr ? ld_addr[AW-1:0] : core_pc[AW-1:0];
    assign mem_wdata  = ld_data;

    assign core_ce    = w_retire;
    assign core_inst  = w_in_run_e ? mem_rdata : r_inst;
    assign core_rst_n = r_core_rst_n;
    assign pc_fault   = r_pc_fault;
    assign running    = (r_state == S_RUN_F) || w_in_run_e;
    assign halted     = (r_state == S_HALT);

    // run-control state machine with registered core reset and fault flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_core_rst_n <= 1'b0;
            r_pc_fault   <= 1'b0;
            r_inst       <= 16'h0000;
            r_stop_seen  <= 1'b0;
            r_one_shot   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_RUN_F;
                        r_core_rst_n <= 1'b1;
                        r_stop_seen  <= 1'b0;
                        r_one_shot   <= 1'b0;
                    end
                end
                S_RUN_F: begin
                    if (stop) r_stop_seen <= 1'b1;
                    if (!w_pc_ok) begin
                        r_pc_fault <= 1'b1;
                        r_state    <= S_HALT;
                    end else begin
                        r_state    <= S_RUN_E;
                    end
                end
                S_RUN_E: begin
                    r_inst      <= mem_rdata;
                    r_stop_seen <= 1'b0;
                    r_one_shot  <= 1'b0;
                    if (w_is_halt || stop || r_stop_seen || r_one_shot)
                        r_state <= S_HALT;
                    else
                        r_state <= S_RUN_F;
                end
                S_HALT: begin
                    if (clr) begin
                        r_state      <= S_IDLE;
                        r_core_rst_n <= 1'b0;
                        r_pc_fault   <= 1'b0;
                        r_inst       <= 16'h0000;
                    end else if (start) begin
                        r_state     <= S_RUN_F;
                        r_stop_seen <= 1'b0;
                        r_one_shot  <= 1'b0;
                    end else if (step) begin
                        r_state     <= S_RUN_F;
                        r_stop_seen <= 1'b0;
                        r_one_shot  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    // count retired instructions; cleared with the core on rst or clr
    always_ff @(posedge clk) begin
        if (rst)
            r_retire_cnt <= 32'd0;
        else if (r_state == S_HALT && clr)
            r_retire_cnt <= 32'd0;
        else if (w_retire)
            r_retire_cnt <= r_retire_cnt + 32'd1;
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_adel_imem_ctrl.sv
// Bench for adel_imem_ctrl: SRAM model, tiny core model, behavioural
// reference of the run controller checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_adel_imem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_ready;
    logic [15:0] ld_addr, ld_data;
    logic        start, stop, step, clr;
    logic [15:0] core_pc, core_inst;
    logic        core_ce, core_rst_n;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        running, halted, pc_fault;
`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int ce_cnt  = 0;

    always #5 clk = ~clk;

    adel_imem_ctrl dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .stop(stop), .step(step), .clr(clr),
        .core_pc(core_pc), .core_inst(core_inst), .core_ce(core_ce), .core_rst_n(core_rst_n),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .running(running), .halted(halted),
`ifdef RETIRE_CNT_EN
        .retire_cnt(retire_cnt),
`endif
        .pc_fault(pc_fault)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- SRAM model ----------------
    logic [15:0] sram [256];
    initial begin
        for (int i = 0; i < 256; i++) sram[i] = 16'h0000;
        mem_rdata = 16'h0000;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    // ---------------- core model ----------------
    // 8xxx: r0 += imm12 ; 2xxx: if r0!=0 jump imm12 ; else pc+1
    logic [15:0] c_pc, c_r0;
    logic        force_pc = 1'b0;
    assign core_pc = force_pc ? 16'd256 : c_pc;
    always @(posedge clk) begin
        if (!core_rst_n) begin
            c_pc <= 16'd0;
            c_r0 <= 16'd0;
        end else if (core_ce) begin
            case (core_inst[15:12])
                4'h8: begin c_r0 <= c_r0 + {4'h0, core_inst[11:0]}; c_pc <= c_pc + 16'd1; end
                4'h2: c_pc <= (c_r0 != 16'd0) ? {4'h0, core_inst[11:0]} : c_pc + 16'd1;
                default: c_pc <= c_pc + 16'd1;
            endcase
        end
    end

    always @(negedge clk) if (core_ce === 1'b1) ce_cnt++;

    // ---------------- behavioural reference ----------------
    // phase: "idle", "fetch", "exec", "halt"
    string       m_phase = "idle";
    logic        m_rstn = 1'b0, m_fault = 1'b0;
    logic [15:0] m_last = 16'h0000;
    bit          m_stop_req = 0, m_single = 0;
    int unsigned m_retired = 0;

    always @(negedge clk) begin
        bit          can_load, write_ok, fetch_ok, e_en, e_ce;
        logic [15:0] e_inst;
        can_load = !rst && (m_phase == "idle" || m_phase == "halt");
        write_ok = ld_valid && can_load && (ld_addr < 16'd256);
        fetch_ok = (m_phase == "fetch") && (core_pc < 16'd256);
        e_en     = write_ok || fetch_ok;
        e_ce     = (m_phase == "exec") && (mem_rdata != 16'h0000);
        e_inst   = (m_phase == "exec") ? mem_rdata : m_last;

        chk("ld_ready", ld_ready, can_load);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, write_ok);
        if (e_en) chk("mem_addr", mem_addr, write_ok ? ld_addr % 256 : core_pc % 256);
        if (write_ok) chk("mem_wdata", mem_wdata, ld_data);
        chk("core_ce", core_ce, e_ce);
        chk("core_inst", core_inst, e_inst);
        chk("core_rst_n", core_rst_n, m_rstn);
        chk("running", running, (m_phase == "fetch" || m_phase == "exec"));
        chk("halted", halted, m_phase == "halt");
        chk("pc_fault", pc_fault, m_fault);
`ifdef RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, m_retired);
`endif

        if (rst) begin
            m_phase = "idle"; m_rstn = 0; m_fault = 0; m_last = 0;
            m_stop_req = 0; m_single = 0; m_retired = 0;
        end else if (m_phase == "idle") begin
            if (start) begin m_phase = "fetch"; m_rstn = 1; m_stop_req = 0; m_single = 0; end
        end else if (m_phase == "fetch") begin
            if (stop) m_stop_req = 1;
            if (core_pc >= 16'd256) begin m_fault = 1; m_phase = "halt"; end
            else m_phase = "exec";
        end else if (m_phase == "exec") begin
            m_last = mem_rdata;
            if (mem_rdata == 16'h0000) m_phase = "halt";
            else begin
                m_retired++;
                m_phase = (stop || m_stop_req || m_single) ? "halt" : "fetch";
            end
            m_stop_req = 0; m_single = 0;
        end else begin
            if (clr) begin m_phase = "idle"; m_rstn = 0; m_fault = 0; m_last = 0; m_retired = 0; end
            else if (start) begin m_phase = "fetch"; m_stop_req = 0; m_single = 0; end
            else if (step) begin m_phase = "fetch"; m_stop_req = 0; m_single = 1; end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        ld_valid = 1; ld_addr = a; ld_data = d;
        tick();
        ld_valid = 0;
    endtask

    task automatic pulse_start(); start = 1; tick(); start = 0; endtask
    task automatic pulse_clr();   clr = 1;   tick(); clr = 0;   endtask

    task automatic wait_halt(input string nm, input int max, output int cyc);
        cyc = 0;
        while (!halted && cyc < max) begin tick(); cyc++; end
        if (!halted) chk({nm, "_timeout"}, 0, 1);
    endtask

    // wait until the controller is in its fetch cycle (reading, not writing)
    task automatic wait_fetch(input string nm, input int max);
        int c = 0;
        while (!(running && mem_en && !mem_we) && c < max) begin tick(); c++; end
        if (!(running && mem_en && !mem_we)) chk({nm, "_timeout"}, 0, 1);
    endtask

    // wait until the controller retires an instruction
    task automatic wait_exec(input string nm, input int max);
        int c = 0;
        while (!(running && core_ce) && c < max) begin tick(); c++; end
        if (!(running && core_ce)) chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, ce0;
        rst = 1; ld_valid = 0; ld_addr = 0; ld_data = 0;
        start = 0; stop = 0; step = 0; clr = 0;
        tick(); tick();
        rst = 0;
        tick();
        chk("rst_running", running, 0);
        chk("rst_halted", halted, 0);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_core_inst", core_inst, 0);

        // 1: two-word program, halts on the 5th cycle after start
        load(16'd0, 16'h8001);
        load(16'd1, 16'h0000);
        ce0 = ce_cnt;
        pulse_start();
        cyc = 1;
        while (!halted && cyc < 20) begin tick(); cyc++; end
        chk("t1_halt_cycle", cyc, 5);
        chk("t1_ce_pulses", ce_cnt - ce0, 1);
        chk("t1_r0", c_r0, 1);
        chk("t1_rst_n", core_rst_n, 1);
`ifdef RETIRE_CNT_EN
        chk("t1_retire", retire_cnt, 1);
`endif

        // 2: endless loop, stop during a fetch cycle
        pulse_clr();
        load(16'd0, 16'h8001);
        load(16'd1, 16'h2000);
        pulse_start();
        repeat (7) tick();
        wait_fetch("t2_fetch", 10);
        ce0 = ce_cnt;
        stop = 1; tick(); stop = 0;
        chk("t2_exec_ce", core_ce, 1);
        tick();
        chk("t2_halted", halted, 1);
        chk("t2_ce_pulses", ce_cnt - ce0, 1);

        // 3: halt word first, patch in HALT, then three single steps
        pulse_clr();
        load(16'd0, 16'h0000);
        ce0 = ce_cnt;
        pulse_start();
        wait_halt("t3_first", 10, cyc);
        chk("t3_no_ce", ce_cnt - ce0, 0);
        load(16'd0, 16'h8001);
        load(16'd1, 16'h8001);
        load(16'd2, 16'h8001);
        load(16'd3, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            ce0 = ce_cnt;
            step = 1; tick(); step = 0;
            chk("t3_step_run", running, 1);
            wait_halt("t3_step", 10, cyc);
            chk("t3_step_ce", ce_cnt - ce0, 1);
        end
        chk("t3_r0", c_r0, 3);
        chk("t3_pc", c_pc, 3);
        ce0 = ce_cnt;
        pulse_start();
        wait_halt("t3_resume", 10, cyc);
        chk("t3_resume_ce", ce_cnt - ce0, 0);

        // 4: pc out of range
        pulse_clr();
        force_pc = 1;
        pulse_start();
        chk("t4_no_fetch", mem_en, 0);
        tick();
        chk("t4_halted", halted, 1);
        chk("t4_fault", pc_fault, 1);
        pulse_clr();
        chk("t4_fault_clr", pc_fault, 0);
        chk("t4_idle", halted | running, 0);
        chk("t4_rst_n", core_rst_n, 0);
        force_pc = 0;

        // 5: out-of-range load in IDLE, and a load attempt while running
        ld_valid = 1; ld_addr = 16'd300; ld_data = 16'hBEEF;
        #1;
        chk("t5_oor_ready", ld_ready, 1);
        chk("t5_oor_we", mem_we, 0);
        tick();
        ld_valid = 0;
        chk("t5_oor_alias", sram[44], 16'h0000);
        load(16'd0, 16'h8001);
        load(16'd1, 16'h2000);
        pulse_start();
        wait_exec("t5_exec", 10);
        ld_valid = 1; ld_addr = 16'd5; ld_data = 16'h1234;
        #1;
        chk("t5_run_ready", ld_ready, 0);
        chk("t5_run_we", mem_we, 0);
        tick();
        ld_valid = 0;
        chk("t5_run_nowrite", sram[5], 16'h0000);

        // 6: reset in the middle of an instruction
        wait_exec("t6_exec", 10);
        rst = 1; tick();
        chk("t6_running", running, 0);
        chk("t6_ce", core_ce, 0);
        chk("t6_rst_n", core_rst_n, 0);
        chk("t6_ld_ready", ld_ready, 0);
`ifdef RETIRE_CNT_EN
        chk("t6_retire", retire_cnt, 0);
`endif
        rst = 0; tick();
        chk("t6_ready_after", ld_ready, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
